cordic_share_arbiter: RTL and testbench
=======================================

Name: cordic_share_arbiter

Overview:
Shares one pipelined Cordic instance among N_REQ requesters.
- Round-robin arbitration, at most one issue per cycle.
- Requester IDs are tracked in an in-order tag FIFO; each result is routed back to the requester that issued it.
- Provides a flush sequence that quiesces the Cordic before a mode change or a power-down.
- Sits between the requester blocks and the Cordic valid_in/valid_out interface.

Parameters:
N_REQ, 4, number of requesters (2..8)
XY_BITS, 16, width of x/y operands and results
PH_BITS, 16, width of the phase operand and result
MAX_OUT, 16, maximum Cordic operations in flight; power of 2, at least the Cordic pipeline depth
ID_W, $clog2(N_REQ), tag width (local parameter)

Ports:
clk  in  1  clock, all logic on the rising edge
RST  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester operation request
req_ready  out  N_REQ  per-requester grant, one-hot or zero
req_x  in  N_REQ*XY_BITS  packed x operands, requester i at [i*XY_BITS +: XY_BITS]
req_y  in  N_REQ*XY_BITS  packed y operands
req_phase  in  N_REQ*PH_BITS  packed phase operands
cor_x_i  out  XY_BITS  to Cordic x_i
cor_y_i  out  XY_BITS  to Cordic y_i
cor_phase_in  out  PH_BITS  to Cordic phase_in
cor_valid_in  out  1  to Cordic valid_in
cor_x_o  in  XY_BITS  from Cordic x_o
cor_y_o  in  XY_BITS  from Cordic y_o
cor_phase_out  in  PH_BITS  from Cordic phase_out
cor_valid_out  in  1  from Cordic valid_out
rsp_valid  out  N_REQ  one-hot, one-cycle result strobe
rsp_x  out  XY_BITS  result x, shared by all requesters
rsp_y  out  XY_BITS  result y
rsp_phase  out  PH_BITS  result phase
flush_req  in  1  level; request quiesce
flush_done  out  1  one-cycle pulse when quiesced
busy  out  1  outstanding count is not 0
err_orphan  out  1  sticky: Cordic result arrived with an empty tag FIFO

Behaviour:
- Reset (RST=0, asynchronous):
  - All outputs 0.
  - Round-robin pointer = 0; tag FIFO empty; outstanding count = 0; FSM in IDLE.
  - The Cordic shares RST, so no in-flight operation survives a reset mid-operation.
  - Results are never reissued after reset.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on any req_valid, when flush_req = 0.
  - RUN → IDLE when outstanding = 0 and req_valid = 0.
  - IDLE or RUN → DRAIN on flush_req = 1.
  - DRAIN → DONE when outstanding = 0, including a pop in the same cycle.
  - DONE: flush_done = 1 for exactly one cycle, then go to IDLE if flush_req = 0, otherwise hold DONE with flush_done = 0.
- Issue gating: no grant in DRAIN or DONE, and no grant while outstanding = MAX_OUT. A pop in the same cycle does not unblock the grant (no combinational path from cor_valid_out to req_ready).
- Arbitration:
  - Combinational search over req_valid starting at the pointer.
  - The first asserted index i gets req_ready[i] = 1.
  - On grant, pointer ← (i+1) mod N_REQ; with no grant the pointer holds.
  - req_ready must never be asserted for a requester whose req_valid is 0.
- Issue timing:
  - Handshake at edge E: cor_x_i, cor_y_i and cor_phase_in register requester i's operands.
  - cor_valid_in = 1 for the cycle after E, 0 otherwise.
  - Tag i is pushed at E; outstanding is incremented at E.
- Return path:
  - On cor_valid_out, the FIFO head tag t is popped and rsp_x, rsp_y, rsp_phase register the Cordic outputs.
  - rsp_valid = 1<<t on the next cycle.
  - rsp_* data hold until the next result.
  - Responses have no backpressure; requesters must accept the strobe.
- Simultaneous push and pop: outstanding is unchanged, and FIFO pointers both advance correctly, including wrap at MAX_OUT.
- Orphan result: cor_valid_out with an empty FIFO → result dropped, no rsp_valid, err_orphan ← 1 until reset.
- Dropped requests: a requester whose req_valid falls without a grant loses nothing; no state is kept per request.

Test Plan:
- Single request: requester 2 asserts valid with x=0x1000, y=0, phase=0x2000; Cordic model latency 8 → cor_valid_in one cycle after the grant with those operands, rsp_valid=4'b0100 nine cycles after cor_valid_in (valid_out + 1), rsp data = model output.
- Fairness: all 4 requesters held valid for 8 grants → grant order 0,1,2,3,0,1,2,3, one grant per cycle, tags return in the same order.
- Saturation: MAX_OUT=16, Cordic latency 20, requester 0 held valid → exactly 16 grants, req_ready low until the first pop, then one grant per pop; outstanding never exceeds 16.
- Flush: 5 operations in flight, then flush_req=1 with req_valid still high → no further grants, flush_done pulses once, one cycle after the 5th cor_valid_out; busy falls in the same cycle.
- Reset mid-operation: drop RST with 3 in flight → all outputs 0 immediately; after release, a new request completes normally with tag routing correct and err_orphan=0.
- Orphan: force cor_valid_out with an empty FIFO → no rsp_valid, err_orphan=1 and held until reset.

Source files
------------

// File: rtl/cordic_share_arbiter.sv
// Round-robin front end that shares one pipelined Cordic among N_REQ requesters,
// routing each result back through an in-order tag FIFO, with a flush/quiesce sequence.
module cordic_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int XY_BITS = 16,
    parameter int PH_BITS = 16,
    parameter int MAX_OUT = 16
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*XY_BITS-1:0]   req_x,
    input  logic [N_REQ*XY_BITS-1:0]   req_y,
    input  logic [N_REQ*PH_BITS-1:0]   req_phase,
    output logic [XY_BITS-1:0]         cor_x_i,
    output logic [XY_BITS-1:0]         cor_y_i,
    output logic [PH_BITS-1:0]         cor_phase_in,
    output logic                       cor_valid_in,
    input  logic [XY_BITS-1:0]         cor_x_o,
    input  logic [XY_BITS-1:0]         cor_y_o,
    input  logic [PH_BITS-1:0]         cor_phase_out,
    input  logic                       cor_valid_out,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [XY_BITS-1:0]         rsp_x,
    output logic [XY_BITS-1:0]         rsp_y,
    output logic [PH_BITS-1:0]         rsp_phase,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       busy,
    output logic                       err_orphan
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int AW    = $clog2(MAX_OUT);
    localparam int CNT_W = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] out_cnt, cnt_nxt;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [ID_W-1:0]  tag_mem [MAX_OUT];

    logic             issue_ok;
    logic             found_p0, gnt_vld_p0;
    logic [ID_W-1:0]  gnt_idx_p0;
    logic [ID_W:0]    scan_sum;
    logic [ID_W-1:0]  scan_idx;
    logic             pop, orphan;

    // Issue gating deliberately ignores cor_valid_out so a pop never frees a slot in the same cycle.
    assign issue_ok = RST && !flush_req && (state == ST_IDLE || state == ST_RUN)
                      && (out_cnt != CNT_W'(MAX_OUT));

    always_comb begin
        found_p0   = 1'b0;
        gnt_idx_p0 = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(N_REQ)) scan_sum = scan_sum - (ID_W+1)'(N_REQ);
            scan_idx = scan_sum[ID_W-1:0];
            if (!found_p0 && req_valid[scan_idx]) begin
                found_p0   = 1'b1;
                gnt_idx_p0 = scan_idx;
            end
        end
    end

    assign gnt_vld_p0 = found_p0 && issue_ok;
    assign req_ready  = gnt_vld_p0 ? (N_REQ'(1) << gnt_idx_p0) : '0;

    assign pop     = cor_valid_out && (out_cnt != '0);
    assign orphan  = cor_valid_out && (out_cnt == '0);
    assign cnt_nxt = out_cnt + CNT_W'(gnt_vld_p0) - CNT_W'(pop);
    assign busy    = (out_cnt != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (flush_req) state_nxt = ST_DRAIN;
                      else if (|req_valid) state_nxt = ST_RUN;
            ST_RUN:   if (flush_req) state_nxt = ST_DRAIN;
                      else if (out_cnt == '0 && !(|req_valid)) state_nxt = ST_IDLE;
            ST_DRAIN: if (cnt_nxt == '0) state_nxt = ST_DONE;
            ST_DONE:  if (!flush_req) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            out_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            flush_done   <= 1'b0;
            err_orphan   <= 1'b0;
            cor_valid_in <= 1'b0;
            cor_x_i      <= '0;
            cor_y_i      <= '0;
            cor_phase_in <= '0;
            rsp_valid    <= '0;
            rsp_x        <= '0;
            rsp_y        <= '0;
            rsp_phase    <= '0;
        end else begin
            state      <= state_nxt;
            out_cnt    <= cnt_nxt;
            flush_done <= (state == ST_DRAIN) && (state_nxt == ST_DONE);
            if (orphan) err_orphan <= 1'b1;
            // issue stage: operands of the granted requester go to the Cordic next cycle
            cor_valid_in <= gnt_vld_p0;
            if (gnt_vld_p0) begin
                rr_ptr       <= (gnt_idx_p0 == ID_W'(N_REQ-1)) ? '0 : gnt_idx_p0 + 1'b1;
                wr_ptr       <= wr_ptr + 1'b1;
                cor_x_i      <= req_x[gnt_idx_p0*XY_BITS +: XY_BITS];
                cor_y_i      <= req_y[gnt_idx_p0*XY_BITS +: XY_BITS];
                cor_phase_in <= req_phase[gnt_idx_p0*PH_BITS +: PH_BITS];
            end
            // return stage: head tag selects the requester that sees the strobe
            rsp_valid <= pop ? (N_REQ'(1) << tag_mem[rd_ptr]) : '0;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rsp_x     <= cor_x_o;
                rsp_y     <= cor_y_o;
                rsp_phase <= cor_phase_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_vld_p0) tag_mem[wr_ptr] <= gnt_idx_p0;
    end

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Randomized bench for cordic_share_arbiter: a latency-configurable Cordic stand-in plus a
// queue-based reference model of grants, tags, outstanding count, flush and orphan behaviour.
`timescale 1ns/1ps
module tb_cordic_share_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int XW = 16;
    localparam int PW = 16;
    localparam int MO = 16;

    logic clk = 1'b0;
    logic RST;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*XW-1:0] req_x, req_y;
    logic [N*PW-1:0] req_phase;
    logic [XW-1:0]   cor_x_i, cor_y_i;
    logic [PW-1:0]   cor_phase_in;
    logic            cor_valid_in;
    logic [XW-1:0]   cor_x_o, cor_y_o;
    logic [PW-1:0]   cor_phase_out;
    logic            cor_valid_out;
    logic [N-1:0]    rsp_valid;
    logic [XW-1:0]   rsp_x, rsp_y;
    logic [PW-1:0]   rsp_phase;
    logic            flush_req, flush_done, busy, err_orphan;

    cordic_share_arbiter #(.N_REQ(N), .XY_BITS(XW), .PH_BITS(PW), .MAX_OUT(MO)) dut (
        .clk(clk), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_phase(req_phase),
        .cor_x_i(cor_x_i), .cor_y_i(cor_y_i), .cor_phase_in(cor_phase_in), .cor_valid_in(cor_valid_in),
        .cor_x_o(cor_x_o), .cor_y_o(cor_y_o), .cor_phase_out(cor_phase_out), .cor_valid_out(cor_valid_out),
        .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_phase(rsp_phase),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] x; logic [15:0] y; logic [15:0] p; } res_t;
    typedef struct { logic [15:0] x; logic [15:0] y; logic [15:0] p; int due; } op_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 8;
    bit force_orphan;

    // reference model state
    op_t  pipe[$];
    int   tag_q[$];
    int   grant_log[$];
    int   grant_cyc[$];
    bit   exp_iss, exp_rsp, exp_fd, m_orphan, in_drain, fd_given, have_out;
    res_t ei, er, r;
    op_t  pe;
    int   er_tag, m_ptr, m_out, m_out_max, g;
    logic [N-1:0] eg;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic res_t cordic_fn(input logic [15:0] x, input logic [15:0] y, input logic [15:0] p);
        res_t o;
        o.x = x ^ p;
        o.y = y + x;
        o.p = p - 16'h1234;
        return o;
    endfunction

    // first asserted requester at or after the pointer, nothing when issue is not allowed
    function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v, input int p, input bit allow);
        logic [N-1:0] one;
        int i;
        one = 1;
        if (allow) begin
            for (int k = 0; k < N; k++) begin
                i = (p + k) % N;
                if (v[i[IW-1:0]]) return one << i;
            end
        end
        return '0;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!RST) begin
            pipe.delete();
            tag_q.delete();
            exp_iss = 0; exp_rsp = 0; exp_fd = 0; m_orphan = 0; in_drain = 0; fd_given = 0;
            m_ptr = 0; m_out = 0;
            cor_valid_out = 1'b0; cor_x_o = '0; cor_y_o = '0; cor_phase_out = '0;
        end else begin
            check_eq("cor_valid_in", 64'(cor_valid_in), 64'(exp_iss));
            if (exp_iss) begin
                check_eq("cor_x_i", 64'(cor_x_i), 64'(ei.x));
                check_eq("cor_y_i", 64'(cor_y_i), 64'(ei.y));
                check_eq("cor_phase_in", 64'(cor_phase_in), 64'(ei.p));
            end
            if (cor_valid_in) begin
                pe.x = cor_x_i; pe.y = cor_y_i; pe.p = cor_phase_in; pe.due = cyc + lat;
                pipe.push_back(pe);
            end
            exp_iss = 0;
            check_eq("rsp_valid", 64'(rsp_valid), exp_rsp ? (64'd1 << er_tag) : 64'd0);
            if (exp_rsp) begin
                check_eq("rsp_x", 64'(rsp_x), 64'(er.x));
                check_eq("rsp_y", 64'(rsp_y), 64'(er.y));
                check_eq("rsp_phase", 64'(rsp_phase), 64'(er.p));
            end
            exp_rsp = 0;
            check_eq("busy", 64'(busy), 64'(m_out != 0));
            check_eq("err_orphan", 64'(err_orphan), 64'(m_orphan));
            check_eq("flush_done", 64'(flush_done), 64'(exp_fd));
            exp_fd = 0;
            eg = exp_grant(req_valid, m_ptr, !flush_req && (m_out < MO));
            check_eq("req_ready", 64'(req_ready), 64'(eg));
            if (eg != '0) begin
                g = onehot_idx(eg);
                tag_q.push_back(g);
                exp_iss = 1;
                ei.x = req_x[g*XW +: XW];
                ei.y = req_y[g*XW +: XW];
                ei.p = req_phase[g*PW +: PW];
                m_ptr = (g + 1) % N;
                m_out++;
                grant_log.push_back(g);
                grant_cyc.push_back(cyc);
            end
            have_out = 0;
            if (pipe.size() != 0 && pipe[0].due == cyc) begin
                pe = pipe.pop_front();
                r = cordic_fn(pe.x, pe.y, pe.p);
                have_out = 1;
            end else if (force_orphan) begin
                r.x = 16'($urandom); r.y = 16'($urandom); r.p = 16'($urandom);
                have_out = 1;
            end
            cor_valid_out = have_out;
            if (have_out) begin
                cor_x_o = r.x; cor_y_o = r.y; cor_phase_out = r.p;
                if (tag_q.size() != 0) begin
                    er_tag = tag_q.pop_front();
                    er = r;
                    exp_rsp = 1;
                    m_out--;
                end else begin
                    m_orphan = 1;
                end
            end
            if (m_out > m_out_max) m_out_max = m_out;
            if (flush_req) begin
                if (in_drain && !fd_given && m_out == 0) begin
                    exp_fd = 1;
                    fd_given = 1;
                end
                in_drain = 1;
            end else begin
                in_drain = 0;
                fd_given = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_ops(input int i, input logic [15:0] x, input logic [15:0] y, input logic [15:0] p);
        req_x[i*XW +: XW] = x;
        req_y[i*XW +: XW] = y;
        req_phase[i*PW +: PW] = p;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) set_ops(i, 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic check_zero(input string t);
        check_eq({t, ".req_ready"}, 64'(req_ready), 64'd0);
        check_eq({t, ".cor_valid_in"}, 64'(cor_valid_in), 64'd0);
        check_eq({t, ".cor_ops"}, 64'({cor_x_i, cor_y_i, cor_phase_in}), 64'd0);
        check_eq({t, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({t, ".rsp_data"}, 64'({rsp_x, rsp_y, rsp_phase}), 64'd0);
        check_eq({t, ".flags"}, 64'({flush_done, busy, err_orphan}), 64'd0);
    endtask

    task automatic wait_grants(input int n, input int bound, output bit ok);
        ok = 0;
        for (int c = 0; c < bound; c++) begin
            if (grant_log.size() >= n) begin ok = 1; break; end
            step();
        end
        if (!ok) check_eq("timeout_grants", 64'(grant_log.size()), 64'(n));
    endtask

    task automatic drain_wait();
        bit ok;
        ok = 0;
        req_valid = '0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (m_out == 0 && pipe.size() == 0) begin ok = 1; break; end
        end
        if (!ok) check_eq("timeout_drain", 64'(m_out), 64'd0);
        repeat (2) step();
    endtask

    task automatic run_one(input int idx, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] p, input bit chk_lat);
        int base, c0, c1;
        bit ok;
        res_t m;
        set_ops(idx, x, y, p);
        base = grant_log.size();
        req_valid = '0;
        req_valid[idx] = 1'b1;
        wait_grants(base + 1, 20, ok);
        req_valid = '0;
        if (!ok) return;
        check_eq("one.grant_idx", 64'(grant_log[base]), 64'(idx));
        ok = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (cor_valid_in) begin ok = 1; break; end
        end
        if (!ok) begin check_eq("timeout_cor_valid_in", 64'd0, 64'd1); return; end
        c0 = cyc;
        ok = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (rsp_valid != '0) begin ok = 1; break; end
        end
        if (!ok) begin check_eq("timeout_rsp", 64'd0, 64'd1); return; end
        c1 = cyc;
        m = cordic_fn(x, y, p);
        check_eq("one.rsp_valid", 64'(rsp_valid), 64'd1 << idx);
        check_eq("one.rsp_data", 64'({rsp_x, rsp_y, rsp_phase}), 64'(m));
        if (chk_lat) check_eq("one.latency", 64'(c1 - c0), 64'd9);
    endtask

    initial begin
        int base, pulses;
        bit ok;
        RST = 1'b0; req_valid = '0; req_x = '0; req_y = '0; req_phase = '0;
        flush_req = 1'b0; force_orphan = 1'b0; m_out_max = 0; lat = 8;
        repeat (2) step();
        check_zero("reset");
        RST = 1'b1;
        step();

        // fairness: all requesters held for 8 grants
        rand_ops();
        base = grant_log.size();
        req_valid = 4'hF;
        wait_grants(base + 8, 40, ok);
        req_valid = '0;
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                check_eq("fair.order", 64'(grant_log[base+i]), 64'(i % 4));
                check_eq("fair.cycle", 64'(grant_cyc[base+i] - grant_cyc[base]), 64'(i));
            end
        end
        drain_wait();

        // single request with known operands
        lat = 8;
        run_one(2, 16'h1000, 16'h0000, 16'h2000, 1'b1);
        drain_wait();

        // random traffic at two latencies
        for (int rnd = 0; rnd < 2; rnd++) begin
            lat = $urandom_range(3, 12);
            for (int c = 0; c < 150; c++) begin
                rand_ops();
                req_valid = 4'($urandom);
                step();
            end
            drain_wait();
        end

        // saturation at MAX_OUT
        lat = 20;
        rand_ops();
        base = grant_log.size();
        req_valid = 4'b0001;
        wait_grants(base + 20, 200, ok);
        req_valid = '0;
        if (ok) begin
            check_eq("sat.first16", 64'(grant_cyc[base+15] - grant_cyc[base]), 64'd15);
            check_eq("sat.after_pop", 64'(grant_cyc[base+16] - grant_cyc[base]), 64'(lat + 2));
        end
        check_eq("sat.max_out", 64'(m_out_max), 64'(MO));
        drain_wait();

        // flush with 5 in flight and requests still pending
        lat = 8;
        rand_ops();
        base = grant_log.size();
        req_valid = 4'b0010;
        wait_grants(base + 5, 30, ok);
        flush_req = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (flush_done) begin
                pulses++;
                check_eq("flush.busy_at_done", 64'(busy), 64'd0);
            end
        end
        check_eq("flush.pulses", 64'(pulses), 64'd1);
        check_eq("flush.grants", 64'(grant_log.size() - base), 64'd5);
        step();
        req_valid = '0;
        repeat (2) step();
        flush_req = 1'b0;
        repeat (3) step();

        // reset with operations in flight
        lat = 10;
        rand_ops();
        req_valid = 4'b1001;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            if (m_out >= 3) begin ok = 1; break; end
            step();
        end
        if (!ok) check_eq("timeout_inflight", 64'(m_out), 64'd3);
        RST = 1'b0;
        #1;
        check_zero("midrst");
        repeat (3) step();
        req_valid = '0;
        RST = 1'b1;
        step();
        run_one(1, 16'h0F0F, 16'h1234, 16'h4000, 1'b0);
        check_eq("post_rst.err_orphan", 64'(err_orphan), 64'd0);
        drain_wait();

        // orphan result, then sticky until reset
        force_orphan = 1'b1;
        step();
        force_orphan = 1'b0;
        repeat (5) step();
        check_eq("orphan.sticky", 64'(err_orphan), 64'd1);
        check_eq("orphan.no_rsp", 64'(rsp_valid), 64'd0);
        RST = 1'b0;
        #1;
        check_eq("orphan.cleared", 64'(err_orphan), 64'd0);
        repeat (2) step();
        RST = 1'b1;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
